// File: rtl/calc_display_pkg.sv
// Shared constants and types for the calculator seven-segment display path.
// Segment codes are stored as {g,f,e,d,c,b,a}, active low.
package calc_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Decimal decode table; codes 10-15 cannot occur in valid BCD and read blank.
    localparam logic [6:0] DIGIT_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, SEG_BLANK,  SEG_BLANK,
        SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_FORMAT
    } state_t;

    // Evaluated only at elaboration to size the overflow threshold.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// One BCD digit to active-low seven-segment code.
module seg_decode
    import calc_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = DIGIT_SEG[bcd];

endmodule

// File: rtl/seg_display_ctrl.sv
// Binary-to-decimal display controller: serial double-dabble conversion,
// leading-zero blanking, sign/overflow formatting and whole-display blink.
module seg_display_ctrl
    import calc_display_pkg::*;
#(
    parameter int DATA_W    = 20,
    parameter int N_DIGITS  = 6,
    parameter int BLINK_DIV = 500
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Tick_1ms,
    input  logic                        Load,
    input  logic [DATA_W-1:0]           Value,
    input  logic                        Sign,
    input  logic                        Blink_en,
    output logic                        Busy,
    output logic                        Overflow,
    output logic [7*(N_DIGITS+1)-1:0]   HEX
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int HEX_W = 7 * (N_DIGITS + 1);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);

    localparam logic [63:0]      LIMIT      = pow10(N_DIGITS);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [HEX_W-1:0] ALL_BLANK  = {HEX_W{1'b1}};

    state_t             state_q;
    logic [DATA_W-1:0]  value_q;
    logic [DATA_W-1:0]  shift_q;
    logic               sign_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               busy_q;
    logic               ovf_q;
    logic [HEX_W-1:0]   hex_q;
    logic [BLK_W-1:0]   blink_cnt_q;
    logic               blink_on_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic [6:0]         digit_seg [N_DIGITS];
    logic [HEX_W-1:0]   img;
    logic               value_ovf;
    logic               seen;

    // Double-dabble correction: any nibble that would reach 10 after the shift gets +3 first.
    // NOTE: every variable driven in always_comb gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_DIGITS; g++) begin : g_dec
            seg_decode u_dec (
                .bcd (bcd_q[4*g +: 4]),
                .seg (digit_seg[g])
            );
        end
    endgenerate

    assign value_ovf = (64'(value_q) >= LIMIT);

    // Assemble the display image from the finished BCD: blank leading zeros, then apply overflow or sign.
    always_comb begin
        img  = ALL_BLANK;
        seen = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if (seen || i == 0) begin
                img[7*i +: 7] = digit_seg[i];
            end
        end
        if (value_ovf) begin
            img          = ALL_BLANK;
            img[14 +: 7] = SEG_E;
            img[7  +: 7] = SEG_R;
            img[0  +: 7] = SEG_R;
        end else if (sign_q && value_q != '0) begin
            img[7*N_DIGITS +: 7] = SEG_MINUS;
        end
    end

    // Control FSM: capture, shift one value bit per clock, then publish image and overflow together.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            value_q   <= '0;
            shift_q   <= '0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            hex_q     <= ALL_BLANK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Load) begin
                        value_q   <= Value;
                        shift_q   <= Value;
                        sign_q    <= Sign;
                        bcd_q     <= '0;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_q     <= {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
                    shift_q   <= shift_q << 1;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q <= ST_FORMAT;
                    end
                end
                ST_FORMAT: begin
                    hex_q   <= img;
                    ovf_q   <= value_ovf;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Blink timer: toggles the phase every BLINK_DIV ticks while enabled, parked "on" otherwise.
    always_ff @(posedge Clock) begin
        if (Reset || !Blink_en) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (Tick_1ms) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLK_W'(1);
            end
        end
    end

    assign HEX      = blink_on_q ? hex_q : ALL_BLANK;
    assign Busy     = busy_q;
    assign Overflow = ovf_q;

endmodule
